// File: rtl/counter_pkg.sv
// Shared constants and types for the loadable up-counter.
// Each clock edge resolves to exactly one counter action.
package counter_pkg;

    localparam int   WIDTH_DEFAULT = 3;
    localparam logic MODE_WRAP     = 1'b0;
    localparam logic MODE_SAT      = 1'b1;

    // Reset is not listed because it is handled inside the flops themselves.
    typedef enum logic [2:0] {
        ACT_HOLD = 3'd0,
        ACT_LOAD = 3'd1,
        ACT_INC  = 3'd2,
        ACT_WRAP = 3'd3,
        ACT_SAT  = 3'd4
    } cnt_action_e;

    // Decides which action is taken from the inputs sampled at the edge.
    function automatic cnt_action_e decode_action(
        input logic load,
        input logic en,
        input logic at_limit,
        input logic sat_mode
    );
        cnt_action_e act;
        act = ACT_HOLD;
        if (load) begin
            act = ACT_LOAD;
        end else if (en) begin
            if (!at_limit) begin
                act = ACT_INC;
            end else if (sat_mode == MODE_SAT) begin
                act = ACT_SAT;
            end else begin
                act = ACT_WRAP;
            end
        end
        return act;
    endfunction

endpackage

// File: rtl/tff_sync.sv
// Toggle flip-flop with a synchronous active-high reset.
// When t is high, the stored bit inverts on the rising edge.
module tff_sync (
    input  logic clk,
    input  logic reset,
    input  logic t,
    output logic q
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q ^ t;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/sync_up_counter_3bit_ld.sv
// Up-counter with a programmable limit, wrap or saturate mode, and a parallel load.
// The count is held in toggle flops; each toggle enable is steered by the selected action.
module sync_up_counter_3bit_ld
    import counter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] limit,
    input  logic             sat_mode,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             carry_out,
    output logic             ovf
);

    logic [WIDTH-1:0] q_bits;
    logic [WIDTH:0]   carry_chain;
    logic [WIDTH-1:0] toggle;
    logic             at_limit;
    cnt_action_e      action;
    logic             ovf_q;
    logic             ovf_d;

    assign at_limit = (q_bits == limit);

    always_comb begin
        action = decode_action(load, en, at_limit, sat_mode);
    end

    assign carry_chain[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            // Bit gi flips on increment only when every lower bit is already set.
            assign carry_chain[gi+1] = carry_chain[gi] & q_bits[gi];

            always_comb begin
                toggle[gi] = 1'b0;
                case (action)
                    ACT_INC:  toggle[gi] = carry_chain[gi];
                    ACT_WRAP: toggle[gi] = q_bits[gi];
                    ACT_LOAD: toggle[gi] = q_bits[gi] ^ din[gi];
                    default:  toggle[gi] = 1'b0;
                endcase
            end

            tff_sync u_tff (
                .clk   (clk),
                .reset (reset),
                .t     (toggle[gi]),
                .q     (q_bits[gi])
            );
        end
    endgenerate

    // The overflow flag is sticky. Only a load or a reset clears it.
    always_comb begin
        ovf_d = ovf_q;
        case (action)
            ACT_LOAD: ovf_d = 1'b0;
            ACT_WRAP: ovf_d = 1'b1;
            ACT_SAT:  ovf_d = 1'b1;
            default:  ovf_d = ovf_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign Q         = q_bits;
    assign tc        = at_limit;
    assign ovf       = ovf_q;
    assign carry_out = en & at_limit & ~load & (sat_mode == MODE_WRAP) & ~reset;

endmodule

// File: tb/tb_sync_up_counter_3bit_ld.sv
// Directed vector table followed by a randomized run against a behavioural model.
`timescale 1ns/1ps
module tb_sync_up_counter_3bit_ld;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [2:0] din = '0;
    logic [2:0] limit = '0;
    logic       sat_mode = 1'b0;
    logic [2:0] Q;
    logic       tc;
    logic       carry_out;
    logic       ovf;

    always #5 clk = ~clk;

    sync_up_counter_3bit_ld #(.WIDTH(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .load      (load),
        .din       (din),
        .limit     (limit),
        .sat_mode  (sat_mode),
        .Q         (Q),
        .tc        (tc),
        .carry_out (carry_out),
        .ovf       (ovf)
    );

    typedef struct {
        bit       rst;
        bit       ld;
        bit       en;
        bit [2:0] din;
        bit [2:0] lim;
        bit       sat;
        bit       exp_carry;
        bit [2:0] exp_q;
        bit       exp_ovf;
        bit       exp_tc;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Behavioural model state: the count as an integer, plus the sticky flag.
    int   m_q   = 0;
    int   m_ovf = 0;

    task automatic add(input bit rst, input bit ld, input bit e, input int d, input int lim,
                       input bit sat, input bit c, input int q, input bit o, input bit t);
        vec_t v;
        v.rst = rst; v.ld = ld; v.en = e; v.din = d[2:0]; v.lim = lim[2:0]; v.sat = sat;
        v.exp_carry = c; v.exp_q = q[2:0]; v.exp_ovf = o; v.exp_tc = t;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Applies one cycle of inputs. Returns the comb outputs sampled before the edge,
    // together with the model's prediction for them, and then advances the model.
    task automatic step(input bit rst, input bit ld, input bit e, input bit [2:0] d,
                        input bit [2:0] lim, input bit sat,
                        output bit carry_pre, output bit tc_pre,
                        output bit m_carry, output bit m_tc);
        @(negedge clk);
        reset = rst; load = ld; en = e; din = d; limit = lim; sat_mode = sat;
        #1;
        carry_pre = carry_out;
        tc_pre    = tc;
        m_tc      = (m_q == int'(lim));
        m_carry   = e && m_tc && !ld && !sat && !rst;
        @(posedge clk);
        if (rst) begin
            m_q = 0; m_ovf = 0;
        end else if (ld) begin
            m_q = int'(d); m_ovf = 0;
        end else if (e) begin
            if (m_q == int'(lim)) begin
                m_ovf = 1;
                if (!sat) m_q = 0;
            end else begin
                m_q = (m_q + 1) % 8;
            end
        end
        #1;
    endtask

    initial begin
        bit c_pre, t_pre, mc, mt;

        // Count 0..7 with limit 7, wrap back to 0, then continue.
        add(1,0,1,0,7,0, 0,0,0,0);
        for (int k = 1; k <= 7; k++) add(0,0,1,0,7,0, 0,k,0,(k == 7));
        add(0,0,1,0,7,0, 1,0,1,0);
        add(0,0,1,0,7,0, 0,1,1,0);
        // Limit 4 in wrap mode.
        add(1,0,0,0,4,0, 0,0,0,0);
        for (int k = 1; k <= 4; k++) add(0,0,1,0,4,0, 0,k,0,(k == 4));
        add(0,0,1,0,4,0, 1,0,1,0);
        add(0,0,1,0,4,0, 0,1,1,0);
        // Limit 5 in saturate mode: the count sticks at 5.
        add(1,0,0,0,5,1, 0,0,0,0);
        for (int k = 1; k <= 8; k++) add(0,0,1,0,5,1, 0,(k > 5) ? 5 : k,(k >= 6),(k >= 5));
        // A load takes priority over en; din above the limit wraps through 7 first.
        add(0,1,0,2,3,0, 0,2,0,0);
        add(0,1,1,6,3,0, 0,6,0,0);
        add(0,0,1,0,3,0, 0,7,0,0);
        add(0,0,1,0,3,0, 0,0,0,0);
        add(0,0,1,0,3,0, 0,1,0,0);
        add(0,0,1,0,3,0, 0,2,0,0);
        add(0,0,1,0,3,0, 0,3,0,1);
        add(0,0,1,0,3,0, 1,0,1,0);
        // A reset beats load and en, then the count holds while en is low.
        add(0,0,1,0,3,0, 0,1,1,0);
        add(0,0,1,0,3,0, 0,2,1,0);
        add(0,0,1,0,3,0, 0,3,1,1);
        add(1,1,1,5,3,0, 0,0,0,0);
        add(0,0,0,0,3,0, 0,0,0,0);
        add(0,0,0,0,3,0, 0,0,0,0);
        // Limit 0: carry_out pulses on every enabled cycle. Saturate mode then suppresses it.
        add(1,0,0,0,0,0, 0,0,0,1);
        add(0,0,1,0,0,0, 1,0,1,1);
        add(0,0,1,0,0,0, 1,0,1,1);
        add(0,0,1,0,0,1, 0,0,1,1);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].ld, vecs[i].en, vecs[i].din, vecs[i].lim, vecs[i].sat,
                 c_pre, t_pre, mc, mt);
            chk($sformatf("vec%0d carry_out", i), c_pre, vecs[i].exp_carry);
            chk($sformatf("vec%0d Q", i), Q, vecs[i].exp_q);
            chk($sformatf("vec%0d ovf", i), ovf, vecs[i].exp_ovf);
            chk($sformatf("vec%0d tc", i), tc, vecs[i].exp_tc);
            $display("vec %0d: rst=%0d ld=%0d en=%0d din=%0d lim=%0d sat=%0d -> Q=%0d ovf=%0d tc=%0d carry=%0d",
                     i, vecs[i].rst, vecs[i].ld, vecs[i].en, vecs[i].din, vecs[i].lim,
                     vecs[i].sat, Q, ovf, tc, c_pre);
        end

        // Random run. The model is already in step with the DUT after the table.
        for (int n = 0; n < 400; n++) begin
            bit r_rst, r_ld, r_en, r_sat;
            bit [2:0] r_din, r_lim;
            r_rst = ($urandom_range(0, 19) == 0);
            r_ld  = ($urandom_range(0, 7) == 0);
            r_en  = ($urandom_range(0, 3) != 0);
            r_sat = ($urandom_range(0, 3) == 0);
            r_din = 3'($urandom_range(0, 7));
            r_lim = 3'($urandom_range(0, 7));
            step(r_rst, r_ld, r_en, r_din, r_lim, r_sat, c_pre, t_pre, mc, mt);
            chk($sformatf("rnd%0d carry_out", n), c_pre, mc);
            chk($sformatf("rnd%0d tc_pre", n), t_pre, mt);
            chk($sformatf("rnd%0d Q", n), Q, m_q);
            chk($sformatf("rnd%0d ovf", n), ovf, m_ovf);
            $display("rnd %0d: rst=%0d ld=%0d en=%0d din=%0d lim=%0d sat=%0d -> Q=%0d ovf=%0d",
                     n, r_rst, r_ld, r_en, r_din, r_lim, r_sat, Q, ovf);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_up_counter_3bit_ld.md
SYNC_UP_COUNTER_3BIT_LD -- requirements
Module: sync_up_counter_3bit_ld

Interface
REQ-001 Parameter: WIDTH, 3, counter width in bits; all Function rules are stated for WIDTH=3.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 en  input  1  count enable.
REQ-005 load  input  1  synchronous parallel load strobe.
REQ-006 din  input  WIDTH  parallel load value.
REQ-007 limit  input  WIDTH  terminal count value (inclusive maximum of the count sequence).
REQ-008 sat_mode  input  1  0 = wrap at limit, 1 = saturate at limit.
REQ-009 Q  output  WIDTH  registered count value.
REQ-010 tc  output  1  terminal count, combinational: Q == limit.
REQ-011 carry_out  output  1  cascade carry, combinational: en & tc & ~load & ~sat_mode & ~reset.
REQ-012 ovf  output  1  registered sticky overflow flag.

Function
REQ-013 Per-edge priority: reset > load > en > hold.
REQ-014 load=1: Q <= din next edge, en ignored; ovf <= 0.
REQ-015 en=1, load=0, Q != limit: Q <= Q+1 modulo 2^WIDTH (7 -> 0 when limit < Q).
REQ-016 en=1, load=0, Q == limit, sat_mode=0: Q <= 0; ovf <= 1.
REQ-017 en=1, load=0, Q == limit, sat_mode=1: Q holds; ovf <= 1.
REQ-018 en=0, load=0: Q and ovf hold.
REQ-019 Latency: one clock from a sampled en/load to the updated Q; tc follows Q with no further cycle of delay.
REQ-020 carry_out is high for exactly the cycle in which the wrap to 0 is committed, which gives one pulse per wrap when counters are cascaded.
REQ-021 din > limit is legal: Q counts up, wraps naturally at 7 -> 0, then continues to limit; tc stays low until Q == limit.
REQ-022 limit = 0: with en=1 and sat_mode=0, Q stays 0, carry_out is high every enabled cycle, and ovf sets.
REQ-023 A change of limit or sat_mode takes effect at the next edge with no internal pipelining.
REQ-024 ovf clears only on reset or load.

Reset
REQ-025 reset=1 at a rising edge: Q <= 0, ovf <= 0, regardless of load or en.
REQ-026 Reset mid-count aborts the sequence; counting resumes from 0 on the first edge with reset=0 and en=1.
REQ-027 No asynchronous reset path exists; the power-up value of Q is undefined until the first reset edge.

Structure
REQ-028 The shared package counter_pkg holds WIDTH_DEFAULT=3 and the mode constants MODE_WRAP=0 and MODE_SAT=1.
REQ-029 One sub-module, tff_sync (toggle flip-flop: clk, reset, t, q; synchronous active-high reset), is instantiated WIDTH times.
REQ-030 Each per-bit toggle enable is the AND of the lower bits of Q (synchronous ripple-free carry chain), gated by the wrap, load and saturate logic.
REQ-031 The load path uses a per-bit toggle t = q XOR din.

Verification
REQ-032 Reset for 1 cycle, limit=7, sat_mode=0, en=1 for 9 cycles -> Q = 0,1,…,7,0,1; carry_out high only while Q=7; ovf=1 after the wrap.
REQ-033 limit=4, sat_mode=0, en=1 from Q=0 -> Q = 0,1,2,3,4,0,1; tc high only at Q=4.
REQ-034 limit=5, sat_mode=1, en=1 for 8 cycles -> Q stops at 5 and holds; ovf=1; carry_out never asserted.
REQ-035 Q=2, load=1 with din=6 and en=1 in the same cycle -> Q=6 next edge and ovf=0; then with limit=3, en=1 -> Q = 7,0,1,2,3,0.
REQ-036 Q=3 with ovf=1, reset=1 with load=1 and en=1 -> Q=0 and ovf=0 next edge; en=0 cycles -> Q holds at 0.
